// File: rtl/sipo_receiver.sv
// -----------------------------------------------------------------------------
// sipo_receiver
//   Receiving end of the serial shift link. One bit is sampled on each rising
//   edge where in_VALID is high. Bits are counted and assembled into
//   WIDTH-bit words. Each completed word moves into a holding register and is
//   offered to the consumer with a READY/ACK handshake. The shift register and
//   the holding register form a double buffer, so the next word can be
//   collected while the consumer reads the current one.
//
// Parameters
//   WIDTH      word length in bits (>= 2)
//   LSB_FIRST  1: first received bit ends in out_DATA[0];
//              0: first received bit ends in out_DATA[WIDTH-1]
//   RST_VALUE  value loaded into the shift and holding registers on reset
//
// Ports
//   clk          in   clock; all state changes on the rising edge
//   rst          in   synchronous, active-high reset; overrides every input
//   in_BIT       in   serial data bit, sampled when in_VALID=1
//   in_VALID     in   bit strobe; one bit is accepted per high cycle
//   in_CLEAR     in   drops the partial word and clears out_OVERRUN
//   in_ACK       in   consumer has taken out_DATA (ignored when out_READY=0)
//   out_DATA     out  holding register; last completed word
//   out_READY    out  out_DATA holds an unconsumed word (holding FSM state)
//   out_COUNT    out  bits collected in the current partial word (0..WIDTH-1)
//   out_OVERRUN  out  sticky flag; a completed word was dropped
//
// Handshake
//   A word is offered while out_READY=1. It counts as consumed on a rising
//   edge where out_READY=1 and in_ACK=1. in_ACK has no effect while
//   out_READY=0. out_READY is the holding FSM state bit itself, so checkers
//   can observe the FSM state directly on that port.
// -----------------------------------------------------------------------------
module sipo_receiver #(
    parameter int                WIDTH     = 8,
    parameter bit                LSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0]  RST_VALUE = '0,
    localparam int               CW        = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_BIT,
    input  logic             in_VALID,
    input  logic             in_CLEAR,
    input  logic             in_ACK,
    output logic [WIDTH-1:0] out_DATA,
    output logic             out_READY,
    output logic [CW-1:0]    out_COUNT,
    output logic             out_OVERRUN
);

    localparam logic [0:0]    ST_EMPTY = 1'b0;
    localparam logic [0:0]    ST_HELD  = 1'b1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q,      sr_d;
    logic [WIDTH-1:0] data_q,    data_d;
    logic [CW-1:0]    count_q,   count_d;
    logic [0:0]       state_q,   state_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] shifted;
    logic             accept;
    logic             complete;

    // The shifted value already contains the incoming bit. On the completing
    // edge it is the finished word.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign shifted = {in_BIT, sr_q[WIDTH-1:1]};
        end else begin : g_msb_first
            assign shifted = {sr_q[WIDTH-2:0], in_BIT};
        end
    endgenerate

    // When in_CLEAR and in_VALID are both high, in_CLEAR wins.
    // The bit on that edge is discarded, so that edge cannot complete a word.
    assign accept   = in_VALID && !in_CLEAR;
    assign complete = accept && (count_q == LAST_CNT);

    always_comb begin
        sr_d      = sr_q;
        count_d   = count_q;
        data_d    = data_q;
        state_d   = state_q;
        overrun_d = overrun_q;

        if (in_CLEAR) begin
            sr_d      = RST_VALUE;
            count_d   = '0;
            overrun_d = 1'b0;
        end else if (in_VALID) begin
            sr_d    = shifted;
            count_d = complete ? '0 : count_q + 1'b1;
        end

        // in_CLEAR does not change the holding side. An ACK on the same
        // edge as in_CLEAR is still honoured.
        case (state_q)
            ST_EMPTY: begin
                if (complete) begin
                    data_d  = shifted;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (complete) begin
                    if (in_ACK) begin
                        data_d = shifted;
                    end else begin
                        // The held word has not been consumed, so the new
                        // word is dropped.
                        overrun_d = 1'b1;
                    end
                end else if (in_ACK) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q      <= RST_VALUE;
            data_q    <= RST_VALUE;
            count_q   <= '0;
            state_q   <= ST_EMPTY;
            overrun_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            data_q    <= data_d;
            count_q   <= count_d;
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_DATA    = data_q;
    assign out_READY   = (state_q == ST_HELD);
    assign out_COUNT   = count_q;
    assign out_OVERRUN = overrun_q;

endmodule

// File: tb/tb_sipo_receiver.sv
// Bench for sipo_receiver. Instance u_lsb uses LSB_FIRST=1.
// Instance u_msb uses LSB_FIRST=0. Inputs change on the falling edge, like
// the real transmitter does. Outputs are sampled 1ns after the rising edge.
module tb_sipo_receiver;

    logic       clk;
    logic       rst;

    logic       a_bit, a_valid, a_clear, a_ack;
    logic [7:0] a_data;
    logic       a_ready, a_overrun;
    logic [3:0] a_count;

    logic       b_bit, b_valid, b_clear, b_ack;
    logic [7:0] b_data;
    logic       b_ready, b_overrun;
    logic [3:0] b_count;

    int tests_run;
    int tests_failed;

    sipo_receiver #(.WIDTH(8), .LSB_FIRST(1'b1), .RST_VALUE(8'h00)) u_lsb (
        .clk         (clk),
        .rst         (rst),
        .in_BIT      (a_bit),
        .in_VALID    (a_valid),
        .in_CLEAR    (a_clear),
        .in_ACK      (a_ack),
        .out_DATA    (a_data),
        .out_READY   (a_ready),
        .out_COUNT   (a_count),
        .out_OVERRUN (a_overrun)
    );

    sipo_receiver #(.WIDTH(8), .LSB_FIRST(1'b0), .RST_VALUE(8'h00)) u_msb (
        .clk         (clk),
        .rst         (rst),
        .in_BIT      (b_bit),
        .in_VALID    (b_valid),
        .in_CLEAR    (b_clear),
        .in_ACK      (b_ack),
        .out_DATA    (b_data),
        .out_READY   (b_ready),
        .out_COUNT   (b_count),
        .out_OVERRUN (b_overrun)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Runs one clock cycle. The task drives the inputs on the falling edge
    // and returns 1ns after the next rising edge.
    task automatic cyc_a(input logic v, input logic b, input logic c, input logic k);
        @(negedge clk);
        a_valid = v; a_bit = b; a_clear = c; a_ack = k;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input logic v, input logic b, input logic c, input logic k);
        @(negedge clk);
        b_valid = v; b_bit = b; b_clear = c; b_ack = k;
        @(posedge clk);
        #1;
    endtask

    // Sends a full word to u_lsb, LSB first.
    // ack_last drives in_ACK on the final bit only.
    task automatic send_word_a(input logic [7:0] w, input logic ack_last);
        for (int i = 0; i < 8; i++)
            cyc_a(1'b1, w[i], 1'b0, (i == 7) ? ack_last : 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        cyc_a(1'b0, 1'b0, 1'b0, 1'b0);
        cyc_a(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tests_run++; if (a_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", a_data); end
        tests_run++; if (a_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", a_ready); end
        tests_run++; if (a_count !== 4'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", a_count); end
        tests_run++; if (a_overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b expected 0", a_overrun); end
        tests_run++; if (b_ready !== 1'b0 || b_data !== 8'h00) begin tests_failed++; $display("FAIL reset_msb: got ready=%b data=%h expected 0/00", b_ready, b_data); end
    endtask

    task automatic test_lsb_word;
        logic [7:0] bits;
        bits = 8'b1010_0101; // bits[i] is the i-th bit sent: 1,0,1,0,0,1,0,1
        for (int i = 0; i < 7; i++) cyc_a(1'b1, bits[i], 1'b0, 1'b0);
        tests_run++; if (a_count !== 4'd7 || a_ready !== 1'b0) begin tests_failed++; $display("FAIL lsb_seven_bits: got count=%0d ready=%b expected 7/0", a_count, a_ready); end
        cyc_a(1'b1, bits[7], 1'b0, 1'b0);
        tests_run++; if (a_data !== 8'hA5) begin tests_failed++; $display("FAIL lsb_data: got %h expected a5", a_data); end
        tests_run++; if (a_ready !== 1'b1) begin tests_failed++; $display("FAIL lsb_ready: got %b expected 1", a_ready); end
        tests_run++; if (a_count !== 4'd0) begin tests_failed++; $display("FAIL lsb_count_wrap: got %0d expected 0", a_count); end
        cyc_a(1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++; if (a_ready !== 1'b0 || a_data !== 8'hA5) begin tests_failed++; $display("FAIL lsb_ack: got ready=%b data=%h expected 0/a5", a_ready, a_data); end
        cyc_a(1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++; if (a_ready !== 1'b0) begin tests_failed++; $display("FAIL ack_when_empty: got ready=%b expected 0", a_ready); end
    endtask

    task automatic test_overrun;
        send_word_a(8'h3C, 1'b0);
        tests_run++; if (a_data !== 8'h3C || a_ready !== 1'b1) begin tests_failed++; $display("FAIL ovr_first: got data=%h ready=%b expected 3c/1", a_data, a_ready); end
        send_word_a(8'h81, 1'b0);
        tests_run++; if (a_data !== 8'h3C) begin tests_failed++; $display("FAIL ovr_data_kept: got %h expected 3c", a_data); end
        tests_run++; if (a_overrun !== 1'b1 || a_ready !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag: got overrun=%b ready=%b expected 1/1", a_overrun, a_ready); end
        cyc_a(1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++; if (a_overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky: got %b expected 1", a_overrun); end
        cyc_a(1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++; if (a_overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear: got %b expected 0", a_overrun); end
        tests_run++; if (a_data !== 8'h3C || a_ready !== 1'b1) begin tests_failed++; $display("FAIL ovr_clear_keeps: got data=%h ready=%b expected 3c/1", a_data, a_ready); end
        // An ACK on the same edge as in_CLEAR is still honoured.
        cyc_a(1'b0, 1'b0, 1'b1, 1'b1);
        tests_run++; if (a_ready !== 1'b0) begin tests_failed++; $display("FAIL clear_with_ack: got ready=%b expected 0", a_ready); end
    endtask

    task automatic test_ack_same_edge;
        send_word_a(8'h55, 1'b0);
        tests_run++; if (a_data !== 8'h55 || a_ready !== 1'b1) begin tests_failed++; $display("FAIL same_edge_hold: got data=%h ready=%b expected 55/1", a_data, a_ready); end
        send_word_a(8'hF0, 1'b1);
        tests_run++; if (a_data !== 8'hF0) begin tests_failed++; $display("FAIL same_edge_data: got %h expected f0", a_data); end
        tests_run++; if (a_ready !== 1'b1 || a_overrun !== 1'b0) begin tests_failed++; $display("FAIL same_edge_flags: got ready=%b overrun=%b expected 1/0", a_ready, a_overrun); end
        cyc_a(1'b0, 1'b0, 1'b0, 1'b1);
        tests_run++; if (a_ready !== 1'b0) begin tests_failed++; $display("FAIL same_edge_release: got ready=%b expected 0", a_ready); end
    endtask

    task automatic test_clear_midword;
        for (int i = 0; i < 5; i++) cyc_a(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc_a(1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++; if (a_count !== 4'd5) begin tests_failed++; $display("FAIL idle_hold_count: got %0d expected 5", a_count); end
        cyc_a(1'b1, 1'b1, 1'b1, 1'b0);
        tests_run++; if (a_count !== 4'd0 || a_ready !== 1'b0) begin tests_failed++; $display("FAIL clear_beats_valid: got count=%0d ready=%b expected 0/0", a_count, a_ready); end
        // All eight bits must come from the new word. A bit left over from
        // before the clear would corrupt it.
        send_word_a(8'h96, 1'b0);
        tests_run++; if (a_data !== 8'h96 || a_ready !== 1'b1 || a_count !== 4'd0) begin tests_failed++; $display("FAIL clean_word: got data=%h ready=%b count=%0d expected 96/1/0", a_data, a_ready, a_count); end
    endtask

    task automatic test_msb_gapped;
        logic [7:0] seq;
        seq = 8'b1100_0001; // sent in order seq[7] down to seq[0]: 1,1,0,0,0,0,0,1
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                tests_run++; if (b_ready !== 1'b0 || b_count !== 4'd7) begin tests_failed++; $display("FAIL msb_pre_last: got ready=%b count=%0d expected 0/7", b_ready, b_count); end
            end
            cyc_b(1'b1, seq[i], 1'b0, 1'b0);
            if (i != 0) begin
                cyc_b(1'b0, 1'b0, 1'b0, 1'b0);
                cyc_b(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        tests_run++; if (b_data !== 8'hC1) begin tests_failed++; $display("FAIL msb_data: got %h expected c1", b_data); end
        tests_run++; if (b_ready !== 1'b1 || b_count !== 4'd0) begin tests_failed++; $display("FAIL msb_ready: got ready=%b count=%0d expected 1/0", b_ready, b_count); end
        cyc_b(1'b0, 1'b0, 1'b0, 1'b0);
        cyc_b(1'b0, 1'b0, 1'b0, 1'b0);
        // Next word: three gapped bits, then rst on the fourth strobe.
        for (int i = 0; i < 3; i++) begin
            cyc_b(1'b1, 1'b1, 1'b0, 1'b0);
            cyc_b(1'b0, 1'b0, 1'b0, 1'b0);
            cyc_b(1'b0, 1'b0, 1'b0, 1'b0);
        end
        tests_run++; if (b_count !== 4'd3 || b_ready !== 1'b1) begin tests_failed++; $display("FAIL msb_partial: got count=%0d ready=%b expected 3/1", b_count, b_ready); end
        rst = 1'b1;
        cyc_b(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        tests_run++; if (b_data !== 8'h00 || b_ready !== 1'b0) begin tests_failed++; $display("FAIL msb_rst_hold: got data=%h ready=%b expected 00/0", b_data, b_ready); end
        tests_run++; if (b_count !== 4'd0 || b_overrun !== 1'b0) begin tests_failed++; $display("FAIL msb_rst_count: got count=%0d overrun=%b expected 0/0", b_count, b_overrun); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        a_bit = 1'b0; a_valid = 1'b0; a_clear = 1'b0; a_ack = 1'b0;
        b_bit = 1'b0; b_valid = 1'b0; b_clear = 1'b0; b_ack = 1'b0;
        test_reset();
        test_lsb_word();
        test_overrun();
        test_ack_same_edge();
        test_clear_midword();
        test_msb_gapped();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
